// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//
// Data-memory target for a core load/store port. One request is accepted at a
// time over a valid/ready handshake. After WAIT_STATES wait cycles the access
// commits, and a registered response is offered on a second valid/ready
// handshake. Loads support byte, half and word sizes with sign or zero
// extension. Stores use byte-lane masking.
//
// Build option:
//   MISALIGN_TRAP_EN  when defined, misaligned half/word accesses fault.
//                     When undefined, the offending low address bits are
//                     ignored.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   reset       synchronous reset, active-high
//   req_valid   request present
//   req_ready   responder can accept (idle and not in reset)
//   req_we      1 = store, 0 = load
//   req_addr    byte address
//   req_wdata   store data, right-aligned
//   req_funct3  RISC-V funct3 of the load/store
//   rsp_valid   response present
//   rsp_ready   requester takes the response
//   rsp_rdata   extended load result, 0 for stores and faults
//   rsp_err     access fault
// ----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [2:0]    acc_f3;
    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          out_of_range;
    logic          bad_f3;
    logic          misaligned;
    logic          fault;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   ld_data;
    logic [31:0]   st_data;
    logic [3:0]    st_mask;
    logic          commit;

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Access decode. With zero wait states the commit edge is the accept edge,
    // so the live request is decoded in IDLE; otherwise the latched copy is.
    always_comb begin
        acc_we       = (state_q == ST_IDLE) ? req_we     : we_q;
        acc_addr     = (state_q == ST_IDLE) ? req_addr   : addr_q;
        acc_wdata    = (state_q == ST_IDLE) ? req_wdata  : wdata_q;
        acc_f3       = (state_q == ST_IDLE) ? req_funct3 : funct3_q;
        // Unsigned wrap makes addresses below BASE_ADDR fall out of range too.
        off          = acc_addr - BASE_ADDR;
        idx          = off[AW+1:2];
        lane         = off[1:0];
        out_of_range = (off >= SPAN);
        rd_word      = mem[idx];
        rd_byte      = rd_word[{lane, 3'b000} +: 8];
        rd_half      = rd_word[{lane[1], 4'b0000} +: 16];
        bad_f3       = 1'b0;
        misaligned   = 1'b0;
        ld_data      = 32'h0;
        st_data      = 32'h0;
        st_mask      = 4'b0000;

        if (acc_we) begin
            case (acc_f3)
                3'b000: begin
                    st_mask = 4'b0001 << lane;
                    st_data = {4{acc_wdata[7:0]}};
                end
                3'b001: begin
                    st_mask = lane[1] ? 4'b1100 : 4'b0011;
                    st_data = {2{acc_wdata[15:0]}};
                end
                3'b010: begin
                    st_mask = 4'b1111;
                    st_data = acc_wdata;
                end
                default: bad_f3 = 1'b1;
            endcase
        end else begin
            case (acc_f3)
                3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
                3'b100:  ld_data = {24'h0, rd_byte};
                3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
                3'b101:  ld_data = {16'h0, rd_half};
                3'b010:  ld_data = rd_word;
                default: bad_f3 = 1'b1;
            endcase
        end

`ifdef MISALIGN_TRAP_EN
        if ((acc_f3[1:0] == 2'b01) && lane[0]) begin
            misaligned = 1'b1;
        end
        if ((acc_f3 == 3'b010) && (lane != 2'b00)) begin
            misaligned = 1'b1;
        end
`endif

        fault = out_of_range || bad_f3 || misaligned;
    end

    // Next-state logic. The response registers are loaded on the edge that
    // enters RESP, which is also the edge the memory is read or written.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        commit      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    we_d     = req_we;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    cnt_d    = WAIT_INIT;
                    if (WAIT_INIT == 4'd0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = fault;
            rsp_rdata_d = (fault || acc_we) ? 32'h0 : ld_data;
        end
    end

    // FSM and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            funct3_q    <= 3'b000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Memory array, never cleared. A reset on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (!reset && commit && acc_we && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (st_mask[i]) begin
                    mem[idx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

endmodule
